// File: rtl/display_pkg.sv
// Shared mode encodings for the display source selector.
// The mode value is exported on a port, so its encoding is fixed here for all users.
package display_pkg;

    localparam int MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_PC   = 2'd0;
    localparam logic [MODE_W-1:0] MODE_REG  = 2'd1;
    localparam logic [MODE_W-1:0] MODE_CYC  = 2'd2;
    localparam logic [MODE_W-1:0] MODE_SNAP = 2'd3;

    typedef enum logic [MODE_W-1:0] {
        ST_PC   = MODE_PC,
        ST_REG  = MODE_REG,
        ST_CYC  = MODE_CYC,
        ST_SNAP = MODE_SNAP
    } mode_state_e;

endpackage

// File: rtl/display_source_sel_btn_debounce.sv
// Push-button conditioning: 2-flop synchronizer, debounce counter, and a one-clock
// press pulse on each accepted rising edge of the stable level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    localparam int CNT_W = 24;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             stable_r;
    logic             stable_d_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronize the raw button, then accept a new level only after it has held long enough.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r    <= 1'b0;
            sync2_r    <= 1'b0;
            stable_r   <= 1'b0;
            stable_d_r <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
        end else begin
            sync1_r    <= btn_raw;
            sync2_r    <= sync1_r;
            stable_d_r <= stable_r;
            if (sync2_r == stable_r) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (cnt_r == CNT_LAST) begin
                stable_r <= sync2_r;
                cnt_r    <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Decoded straight from two flops so the mode FSM can react in the following edge.
    assign press = stable_r & ~stable_d_r;

endmodule

// File: rtl/display_source_sel.sv
// Selects the word sent to the 7-segment display driver: PC, register value,
// saturating CPU cycle count, or the register value captured when the CPU halted.
module display_source_sel
    import display_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int WIDTH           = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_next,
    input  logic              halt,
    input  logic              cycle_en,
    input  logic [WIDTH-1:0]  pc,
    input  logic [WIDTH-1:0]  reg_val,
    output logic [MODE_W-1:0] mode,
    output logic [WIDTH-1:0]  data_to_show
);

    logic             press_s;
    mode_state_e      state_r;
    mode_state_e      state_s;
    logic [WIDTH-1:0] cycle_cnt_r;
    logic [WIDTH-1:0] snapshot_r;
    logic             halt_d_r;
    logic [WIDTH-1:0] mux_s;
    logic [WIDTH-1:0] data_r;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_raw(btn_next),
        .press  (press_s)
    );

    // Mode state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_PC;
        end else begin
            state_r <= state_s;
        end
    end

    // Mode sequencing: advance one step per accepted press, wrapping back to PC.
    always_comb begin
        state_s = state_r;
        if (press_s) begin
            case (state_r)
                ST_PC:   state_s = ST_REG;
                ST_REG:  state_s = ST_CYC;
                ST_CYC:  state_s = ST_SNAP;
                ST_SNAP: state_s = ST_PC;
                default: state_s = ST_PC;
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Cycle counter saturates instead of wrapping so an overflow is never mistaken for a small count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_r <= {WIDTH{1'b0}};
        end else if (cycle_en && !halt && (cycle_cnt_r != {WIDTH{1'b1}})) begin
            cycle_cnt_r <= cycle_cnt_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Capture the register value on the halt rising edge, independent of the current mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_d_r   <= 1'b0;
            snapshot_r <= {WIDTH{1'b0}};
        end else begin
            halt_d_r <= halt;
            if (halt && !halt_d_r) begin
                snapshot_r <= reg_val;
            end
        end
    end

    // Source select for the display word.
    always_comb begin
        mux_s = {WIDTH{1'b0}};
        case (state_r)
            ST_PC:   mux_s = pc;
            ST_REG:  mux_s = reg_val;
            ST_CYC:  mux_s = cycle_cnt_r;
            ST_SNAP: mux_s = snapshot_r;
            default: mux_s = {WIDTH{1'b0}};
        endcase
    end

    // Output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r <= {WIDTH{1'b0}};
        end else begin
            data_r <= mux_s;
        end
    end

    assign mode         = state_r;
    assign data_to_show = data_r;

endmodule
